// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex display scheduler.
// Requester ids double as the disp_src encoding.
package hex_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } disp_state_e;

    localparam logic SRC_UART = 1'b0;
    localparam logic SRC_PUF  = 1'b1;

    // 1 s at 50 MHz
    localparam int unsigned DWELL_CYCLES_DEFAULT = 50_000_000;

endpackage

// File: rtl/hex_display_scheduler_dwell_timer.sv
// Dwell down-counter: reloads on load, counts down while not held, parks at zero.
// done flags terminal count so the scheduler can close the dwell window.
module dwell_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (!hold && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/hex_display_scheduler.sv
// Round-robin scheduler sharing the hex byte display between UART and PUF producers.
// Each accepted byte is held on hex_byte for DWELL_CYCLES unheld clocks.
//
// state | meaning
// IDLE  | waiting for a request; arbitration active, readies may assert
// SHOW  | byte on display, dwell timer running (frozen by hold)
module hex_display_scheduler
    import hex_disp_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_byte,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_byte,
    output logic       req1_ready,
    input  logic       hold,
    output logic [7:0] hex_byte,
    output logic       disp_active,
    output logic       disp_src
);

    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);

    disp_state_e state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  hex_byte_q, hex_byte_d;
    logic        disp_active_q, disp_active_d;
    logic        disp_src_q, disp_src_d;
    logic        timer_load;
    logic        timer_done;

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (DWELL_RELOAD),
        .hold     (hold),
        .done     (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= SRC_PUF;
            hex_byte_q    <= 8'h00;
            disp_active_q <= 1'b0;
            disp_src_q    <= SRC_UART;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            hex_byte_q    <= hex_byte_d;
            disp_active_q <= disp_active_d;
            disp_src_q    <= disp_src_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        hex_byte_d    = hex_byte_q;
        disp_active_d = disp_active_q;
        disp_src_d    = disp_src_q;
        timer_load    = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time gets the slot.
                if (!hold) begin
                    if (req0_valid && (!req1_valid || (last_grant_q == SRC_PUF))) begin
                        req0_ready = 1'b1;
                    end else if (req1_valid) begin
                        req1_ready = 1'b1;
                    end
                end
                if (req0_ready || req1_ready) begin
                    state_d       = SHOW;
                    timer_load    = 1'b1;
                    disp_active_d = 1'b1;
                    hex_byte_d    = req1_ready ? req1_byte : req0_byte;
                    disp_src_d    = req1_ready ? SRC_PUF : SRC_UART;
                    last_grant_d  = req1_ready ? SRC_PUF : SRC_UART;
                end
            end
            SHOW: begin
                if (!hold && timer_done) begin
                    state_d       = IDLE;
                    disp_active_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hex_byte    = hex_byte_q;
    assign disp_active = disp_active_q;
    assign disp_src    = disp_src_q;

endmodule
